// File: rtl/wakeup_select_queue_if.sv
// Bus bundle for wakeup_select_queue: rename enqueue, result broadcasts, head age,
// and the issue port toward execute. The queue takes the slave modport.
interface wakeup_select_queue_if #(
    parameter int DEPTH     = 16,
    parameter int PAYLOAD_W = 138,
    parameter int NUM_SRC   = 3,
    parameter int NUM_BCAST = 2,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int AGE_W     = 8
) ();
    logic                        enq_valid;
    logic                        enq_ready;
    logic [PAYLOAD_W-1:0]        enq_payload;
    logic [AGE_W-1:0]            enq_age;
    logic                        enq_serial;
    logic [NUM_SRC*TAG_W-1:0]    enq_tag;
    logic [NUM_SRC-1:0]          enq_src_rdy;
    logic [NUM_SRC*DATA_W-1:0]   enq_src_val;
    logic [NUM_BCAST-1:0]        bcast_valid;
    logic [NUM_BCAST*TAG_W-1:0]  bcast_tag;
    logic [NUM_BCAST*DATA_W-1:0] bcast_val;
    logic [AGE_W-1:0]            head_age;
    logic                        deq_ready;
    logic                        deq_valid;
    logic [PAYLOAD_W-1:0]        deq_payload;
    logic [NUM_SRC*DATA_W-1:0]   deq_src_val;
    logic [AGE_W-1:0]            deq_age;
    logic [$clog2(DEPTH):0]      count;

    modport master (
        output enq_valid, enq_payload, enq_age, enq_serial, enq_tag, enq_src_rdy, enq_src_val,
               bcast_valid, bcast_tag, bcast_val, head_age, deq_ready,
        input  enq_ready, deq_valid, deq_payload, deq_src_val, deq_age, count
    );
    modport slave (
        input  enq_valid, enq_payload, enq_age, enq_serial, enq_tag, enq_src_rdy, enq_src_val,
               bcast_valid, bcast_tag, bcast_val, head_age, deq_ready,
        output enq_ready, deq_valid, deq_payload, deq_src_val, deq_age, count
    );
endinterface

// File: rtl/wakeup_select_queue.sv
// Out-of-order issue queue with broadcast wakeup and one issue per cycle into a held output register.
// Define AGE_SELECT_EN for oldest-first select; otherwise lowest-index eligible entry issues.
module wsq_entry #(
    parameter int PAYLOAD_W = 138,
    parameter int NUM_SRC   = 3,
    parameter int NUM_BCAST = 2,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int AGE_W     = 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic                        clr,
    input  logic [PAYLOAD_W-1:0]        wr_payload,
    input  logic [AGE_W-1:0]            wr_age,
    input  logic                        wr_serial,
    input  logic [NUM_SRC*TAG_W-1:0]    wr_tag,
    input  logic [NUM_SRC-1:0]          wr_src_rdy,
    input  logic [NUM_SRC*DATA_W-1:0]   wr_src_val,
    input  logic [NUM_BCAST-1:0]        bcast_valid,
    input  logic [NUM_BCAST*TAG_W-1:0]  bcast_tag,
    input  logic [NUM_BCAST*DATA_W-1:0] bcast_val,
    input  logic [AGE_W-1:0]            head_age,
    output logic                        valid,
    output logic                        elig,
    output logic [PAYLOAD_W-1:0]        payload,
    output logic [AGE_W-1:0]            age,
    output logic [NUM_SRC*DATA_W-1:0]   src_val
);
    logic                             serial;
    logic [NUM_SRC-1:0]               rdy;
    logic [NUM_SRC-1:0][TAG_W-1:0]    tag;
    logic [NUM_SRC-1:0][DATA_W-1:0]   val;
    logic [NUM_SRC-1:0]               hit, whit, wimm;
    logic [NUM_SRC-1:0][DATA_W-1:0]   hval, whval;

    // Scan channels high to low so the lowest matching channel's value is kept.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            hit[k]   = 1'b0;
            hval[k]  = '0;
            whit[k]  = 1'b0;
            whval[k] = '0;
            wimm[k]  = wr_src_rdy[k] | (wr_tag[k*TAG_W +: TAG_W] == '0);
            for (int c = NUM_BCAST-1; c >= 0; c--) begin
                if (bcast_valid[c] && tag[k] != '0 && bcast_tag[c*TAG_W +: TAG_W] == tag[k]) begin
                    hit[k]  = 1'b1;
                    hval[k] = bcast_val[c*DATA_W +: DATA_W];
                end
                if (bcast_valid[c] && bcast_tag[c*TAG_W +: TAG_W] == wr_tag[k*TAG_W +: TAG_W]) begin
                    whit[k]  = 1'b1;
                    whval[k] = bcast_val[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid   <= 1'b0;
            serial  <= 1'b0;
            payload <= '0;
            age     <= '0;
            rdy     <= '0;
            tag     <= '0;
            val     <= '0;
        end else if (flush || clr) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid   <= 1'b1;
            serial  <= wr_serial;
            payload <= wr_payload;
            age     <= wr_age;
            for (int k = 0; k < NUM_SRC; k++) begin
                tag[k] <= wr_tag[k*TAG_W +: TAG_W];
                rdy[k] <= wimm[k] | whit[k];
                val[k] <= wimm[k] ? wr_src_val[k*DATA_W +: DATA_W] : whval[k];
            end
        end else if (valid) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!rdy[k] && hit[k]) begin
                    rdy[k] <= 1'b1;
                    val[k] <= hval[k];
                end
            end
        end
    end

    assign elig    = valid & (&rdy) & (~serial | (age == head_age));
    assign src_val = val;
endmodule

module wakeup_select_queue #(
    parameter int DEPTH     = 16,
    parameter int PAYLOAD_W = 138,
    parameter int NUM_SRC   = 3,
    parameter int NUM_BCAST = 2,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int AGE_W     = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic FLUSH,
    wakeup_select_queue_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]                     e_vld, e_elig, wr_sel, clr_sel;
    logic [DEPTH-1:0][PAYLOAD_W-1:0]      e_pay;
    logic [DEPTH-1:0][AGE_W-1:0]          e_age;
    logic [DEPTH-1:0][NUM_SRC*DATA_W-1:0] e_val;
    logic [CNT_W-1:0]                     cnt;
    logic [IDX_W-1:0]                     sel;
    logic                                 enq_rdy, enq_fire, any_elig, issue, free_found;
    logic                                 dq_vld;
    logic [PAYLOAD_W-1:0]                 dq_pay;
    logic [NUM_SRC*DATA_W-1:0]            dq_val;
    logic [AGE_W-1:0]                     dq_age;

    assign enq_rdy  = (cnt != CNT_W'(DEPTH));
    assign enq_fire = bus.enq_valid & enq_rdy & ~FLUSH;
    assign issue    = bus.deq_ready & ~FLUSH & any_elig;

    always_comb begin
        wr_sel     = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!e_vld[i] && !free_found) begin
                wr_sel[i]  = 1'b1;
                free_found = 1'b1;
            end
        end
    end

`ifdef AGE_SELECT_EN
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] d;
        d = a - b;
        return d[AGE_W-1];
    endfunction

    logic [AGE_W-1:0] best_age;
    always_comb begin
        any_elig = 1'b0;
        sel      = '0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_elig[i] && (!any_elig || older(e_age[i], best_age))) begin
                any_elig = 1'b1;
                sel      = IDX_W'(i);
                best_age = e_age[i];
            end
        end
    end
`else
    always_comb begin
        any_elig = 1'b0;
        sel      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_elig[i] && !any_elig) begin
                any_elig = 1'b1;
                sel      = IDX_W'(i);
            end
        end
    end
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign clr_sel[i] = issue && (sel == IDX_W'(i));
        wsq_entry #(
            .PAYLOAD_W(PAYLOAD_W), .NUM_SRC(NUM_SRC), .NUM_BCAST(NUM_BCAST),
            .TAG_W(TAG_W), .DATA_W(DATA_W), .AGE_W(AGE_W)
        ) u_ent (
            .CLK        (CLK),
            .RESET      (RESET),
            .flush      (FLUSH),
            .wr_en      (enq_fire & wr_sel[i]),
            .clr        (clr_sel[i]),
            .wr_payload (bus.enq_payload),
            .wr_age     (bus.enq_age),
            .wr_serial  (bus.enq_serial),
            .wr_tag     (bus.enq_tag),
            .wr_src_rdy (bus.enq_src_rdy),
            .wr_src_val (bus.enq_src_val),
            .bcast_valid(bus.bcast_valid),
            .bcast_tag  (bus.bcast_tag),
            .bcast_val  (bus.bcast_val),
            .head_age   (bus.head_age),
            .valid      (e_vld[i]),
            .elig       (e_elig[i]),
            .payload    (e_pay[i]),
            .age        (e_age[i]),
            .src_val    (e_val[i])
        );
    end

    // Stall holds the output register untouched; nothing leaves the array meanwhile.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dq_vld <= 1'b0;
            dq_pay <= '0;
            dq_val <= '0;
            dq_age <= '0;
            cnt    <= '0;
        end else if (FLUSH) begin
            dq_vld <= 1'b0;
            cnt    <= '0;
        end else begin
            if (bus.deq_ready) begin
                dq_vld <= any_elig;
                if (any_elig) begin
                    dq_pay <= e_pay[sel];
                    dq_val <= e_val[sel];
                    dq_age <= e_age[sel];
                end
            end
            cnt <= cnt + {{(CNT_W-1){1'b0}}, enq_fire} - {{(CNT_W-1){1'b0}}, issue};
        end
    end

    assign bus.enq_ready   = enq_rdy;
    assign bus.count       = cnt;
    assign bus.deq_valid   = dq_vld;
    assign bus.deq_payload = dq_pay;
    assign bus.deq_src_val = dq_val;
    assign bus.deq_age     = dq_age;
endmodule

// File: tb/tb_wakeup_select_queue.sv
// Directed and randomized bench for wakeup_select_queue against a slot-level reference model.
module tb_wakeup_select_queue;
    localparam int DEPTH = 16, PW = 138, NS = 3, NB = 2, TW = 6, DW = 32, AW = 8;

    logic CLK = 1'b0, RESET = 1'b0, FLUSH = 1'b0;
    int   nchk = 0, nerr = 0;

    wakeup_select_queue_if #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .NUM_SRC(NS), .NUM_BCAST(NB),
                             .TAG_W(TW), .DATA_W(DW), .AGE_W(AW)) bus ();
    wakeup_select_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .NUM_SRC(NS), .NUM_BCAST(NB),
                          .TAG_W(TW), .DATA_W(DW), .AGE_W(AW))
        dut (.CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .bus(bus));

    always #5 CLK = ~CLK;

    // Reference model: contents of each slot plus the expected output register.
    bit              m_v   [DEPTH];
    bit              m_ser [DEPTH];
    logic [PW-1:0]   m_pay [DEPTH];
    logic [AW-1:0]   m_age [DEPTH];
    logic [TW-1:0]   m_tag [DEPTH][NS];
    bit              m_rdy [DEPTH][NS];
    logic [DW-1:0]   m_val [DEPTH][NS];
    bit              x_dv = 0;
    logic [PW-1:0]   x_pay = '0;
    logic [NS*DW-1:0] x_sv = '0;
    logic [AW-1:0]   x_age = '0;
    int              x_cnt = 0;

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit older(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] d;
        d = a - b;
        return d[AW-1];
    endfunction

    function automatic bit bmatch(input logic [TW-1:0] t, output logic [DW-1:0] v);
        v = '0;
        for (int c = 0; c < NB; c++)
            if (bus.bcast_valid[c] && bus.bcast_tag[c*TW +: TW] == t) begin
                v = bus.bcast_val[c*DW +: DW];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic bit eligible(input int i);
        bit r;
        r = m_v[i] && (!m_ser[i] || m_age[i] == bus.head_age);
        for (int k = 0; k < NS; k++) r = r && m_rdy[i][k];
        return r;
    endfunction

    task automatic model_step();
        int s, f;
        logic [DW-1:0] bv;
        if (FLUSH) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
            x_dv = 0;
        end else begin
            s = -1;
            if (bus.deq_ready) begin
                for (int i = 0; i < DEPTH; i++)
                    if (eligible(i)) begin
                        if (s < 0) s = i;
`ifdef AGE_SELECT_EN
                        else if (older(m_age[i], m_age[s])) s = i;
`endif
                    end
                x_dv = (s >= 0);
                if (s >= 0) begin
                    x_pay = m_pay[s];
                    x_age = m_age[s];
                    for (int k = 0; k < NS; k++) x_sv[k*DW +: DW] = m_val[s][k];
                end
            end
            f = -1;
            if (x_cnt < DEPTH)
                for (int i = DEPTH-1; i >= 0; i--) if (!m_v[i]) f = i;
            for (int i = 0; i < DEPTH; i++)
                if (m_v[i])
                    for (int k = 0; k < NS; k++)
                        if (!m_rdy[i][k] && m_tag[i][k] != 0 && bmatch(m_tag[i][k], bv)) begin
                            m_rdy[i][k] = 1;
                            m_val[i][k] = bv;
                        end
            if (s >= 0) m_v[s] = 0;
            if (bus.enq_valid && f >= 0) begin
                m_v[f]   = 1;
                m_ser[f] = bus.enq_serial;
                m_pay[f] = bus.enq_payload;
                m_age[f] = bus.enq_age;
                for (int k = 0; k < NS; k++) begin
                    m_tag[f][k] = bus.enq_tag[k*TW +: TW];
                    m_val[f][k] = bus.enq_src_val[k*DW +: DW];
                    m_rdy[f][k] = bus.enq_src_rdy[k] || m_tag[f][k] == 0;
                    if (!m_rdy[f][k] && bmatch(m_tag[f][k], bv)) begin
                        m_rdy[f][k] = 1;
                        m_val[f][k] = bv;
                    end
                end
            end
        end
        x_cnt = 0;
        for (int i = 0; i < DEPTH; i++) x_cnt += int'(m_v[i]);
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("m_deq_valid", 256'(bus.deq_valid), 256'(x_dv));
        chk("m_count", 256'(bus.count), 256'(x_cnt));
        chk("m_enq_ready", 256'(bus.enq_ready), 256'(x_cnt < DEPTH));
        if (x_dv) begin
            chk("m_deq_age", 256'(bus.deq_age), 256'(x_age));
            chk("m_deq_payload", 256'(bus.deq_payload), 256'(x_pay));
            chk("m_deq_src_val", 256'(bus.deq_src_val), 256'(x_sv));
        end
    endtask

    task automatic set_enq(input logic [AW-1:0] age, input bit ser, input logic [NS*TW-1:0] tags,
                           input logic [NS-1:0] rdy, input logic [NS*DW-1:0] vals);
        bus.enq_valid   = 1;
        bus.enq_age     = age;
        bus.enq_serial  = ser;
        bus.enq_tag     = tags;
        bus.enq_src_rdy = rdy;
        bus.enq_src_val = vals;
        bus.enq_payload = PW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic idle();
        bus.enq_valid   = 0;
        bus.bcast_valid = '0;
    endtask

    task automatic do_flush();
        idle();
        FLUSH = 1;
        tick();
        FLUSH = 0;
    endtask

    logic [AW-1:0] age_ctr;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
        bus.enq_valid = 0; bus.enq_payload = '0; bus.enq_age = '0; bus.enq_serial = 0;
        bus.enq_tag = '0; bus.enq_src_rdy = '0; bus.enq_src_val = '0;
        bus.bcast_valid = '0; bus.bcast_tag = '0; bus.bcast_val = '0;
        bus.head_age = '0; bus.deq_ready = 1;
        #12;
        chk("rst_deq_valid", 256'(bus.deq_valid), 256'(0));
        chk("rst_deq_payload", 256'(bus.deq_payload), 256'(0));
        chk("rst_deq_src_val", 256'(bus.deq_src_val), 256'(0));
        chk("rst_deq_age", 256'(bus.deq_age), 256'(0));
        chk("rst_count", 256'(bus.count), 256'(0));
        chk("rst_enq_ready", 256'(bus.enq_ready), 256'(1));
        @(negedge CLK);
        RESET = 1;

        // Single ready instruction: enqueue edge, then issue edge.
        set_enq(8'd5, 0, '0, '0, {32'd3, 32'd2, 32'd1});
        tick();
        idle();
        chk("t1_count_after_enq", 256'(bus.count), 256'(1));
        chk("t1_not_yet_valid", 256'(bus.deq_valid), 256'(0));
        tick();
        chk("t1_deq_valid", 256'(bus.deq_valid), 256'(1));
        chk("t1_deq_src_val", 256'(bus.deq_src_val), 256'({32'd3, 32'd2, 32'd1}));
        chk("t1_deq_age", 256'(bus.deq_age), 256'(5));
        chk("t1_count", 256'(bus.count), 256'(0));
        tick();
        chk("t1_drain", 256'(bus.deq_valid), 256'(0));

        // Late wakeup on channel 1.
        set_enq(8'd6, 0, {6'd0, 6'd0, 6'h12}, 3'b110, {32'd9, 32'd8, 32'd0});
        tick();
        idle();
        tick();
        bus.bcast_valid = 2'b10; bus.bcast_tag = {6'h12, 6'h00}; bus.bcast_val = {32'hDEAD, 32'h0};
        tick();
        idle();
        chk("t2_no_same_edge_issue", 256'(bus.deq_valid), 256'(0));
        tick();
        chk("t2_wake_issue", 256'(bus.deq_valid), 256'(1));
        chk("t2_wake_val", 256'(bus.deq_src_val), 256'({32'd9, 32'd8, 32'hDEAD}));

        // Broadcast in the enqueue cycle, both channels matching: channel 0 wins.
        set_enq(8'd7, 0, {6'd0, 6'd0, 6'h13}, 3'b110, {32'd5, 32'd4, 32'd0});
        bus.bcast_valid = 2'b11; bus.bcast_tag = {6'h13, 6'h13}; bus.bcast_val = {32'h222, 32'h111};
        tick();
        idle();
        tick();
        chk("t2_enq_capture", 256'(bus.deq_src_val), 256'({32'd5, 32'd4, 32'h111}));

        // Fill to DEPTH with unready sources, then wake one.
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            set_enq(AW'(20 + i), 0, {6'd0, 6'd0, 6'(6'h20 + i)}, 3'b110, '0);
            tick();
        end
        chk("t3_full_count", 256'(bus.count), 256'(DEPTH));
        chk("t3_full_ready", 256'(bus.enq_ready), 256'(0));
        set_enq(8'd99, 0, '0, '1, '0);
        tick();
        chk("t3_enq_ignored", 256'(bus.count), 256'(DEPTH));
        idle();
        bus.bcast_valid = 2'b01; bus.bcast_tag = {6'h00, 6'h25}; bus.bcast_val = {32'h0, 32'd7};
        tick();
        idle();
        tick();
        chk("t3_issue_count", 256'(bus.count), 256'(DEPTH - 1));
        chk("t3_issue_ready", 256'(bus.enq_ready), 256'(1));
        chk("t3_issue_age", 256'(bus.deq_age), 256'(25));

        // Selection order across wrapped ages.
        do_flush();
        bus.deq_ready = 0;
        set_enq(8'd3, 0, '0, '1, '0);   tick();
        set_enq(8'd10, 0, '0, '1, '0);  tick();
        set_enq(8'd250, 0, '0, '1, '0); tick();
        idle();
        bus.deq_ready = 1;
`ifdef AGE_SELECT_EN
        tick(); chk("t4_first", 256'(bus.deq_age), 256'(250));
        tick(); chk("t4_second", 256'(bus.deq_age), 256'(3));
        tick(); chk("t4_third", 256'(bus.deq_age), 256'(10));
`else
        tick(); chk("t4_first", 256'(bus.deq_age), 256'(3));
        tick(); chk("t4_second", 256'(bus.deq_age), 256'(10));
        tick(); chk("t4_third", 256'(bus.deq_age), 256'(250));
`endif

        // Serial entry waits for the ROB head.
        bus.head_age = 8'd6;
        set_enq(8'd7, 1, '0, '1, '0);
        tick();
        idle();
        tick();
        chk("t5_serial_blocked", 256'(bus.deq_valid), 256'(0));
        bus.head_age = 8'd7;
        tick();
        chk("t5_serial_issue", 256'(bus.deq_valid), 256'(1));
        chk("t5_serial_age", 256'(bus.deq_age), 256'(7));

        // Stall holds outputs; flush overrides the stall.
        set_enq(8'd40, 0, '0, '1, {32'd1, 32'd2, 32'd3});
        tick();
        idle();
        tick();
        bus.deq_ready = 0;
        set_enq(8'd41, 0, '0, '1, '0);
        tick();
        idle();
        tick();
        tick();
        chk("t6_stall_valid", 256'(bus.deq_valid), 256'(1));
        chk("t6_stall_age", 256'(bus.deq_age), 256'(40));
        chk("t6_stall_val", 256'(bus.deq_src_val), 256'({32'd1, 32'd2, 32'd3}));
        chk("t6_stall_count", 256'(bus.count), 256'(1));
        do_flush();
        chk("t6_flush_valid", 256'(bus.deq_valid), 256'(0));
        chk("t6_flush_count", 256'(bus.count), 256'(0));
        bus.deq_ready = 1;

        // Randomized traffic.
        age_ctr = 8'd100;
        for (int n = 0; n < 600; n++) begin
            bus.enq_valid = ($urandom_range(0, 3) != 0);
            if (bus.enq_valid) begin
                logic [NS*TW-1:0] tg;
                for (int k = 0; k < NS; k++) tg[k*TW +: TW] = TW'($urandom_range(0, 7));
                set_enq(age_ctr, ($urandom_range(0, 7) == 0), tg, NS'($urandom()),
                        NS*DW'({$urandom(), $urandom(), $urandom()}));
                if (bus.enq_ready) age_ctr = age_ctr + 1'b1;
            end
            bus.bcast_valid = NB'($urandom());
            for (int c = 0; c < NB; c++) begin
                bus.bcast_tag[c*TW +: TW] = TW'($urandom_range(1, 7));
                bus.bcast_val[c*DW +: DW] = $urandom();
            end
            bus.head_age  = age_ctr - AW'($urandom_range(1, 4));
            bus.deq_ready = ($urandom_range(0, 4) != 0);
            FLUSH         = ($urandom_range(0, 63) == 0);
            tick();
        end
        FLUSH = 0;
        idle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/wakeup_select_queue.md
# wakeup_select_queue

Parametrised out-of-order issue queue: holds renamed instructions, captures source operands from a configurable number of result-broadcast channels, and issues one ready instruction per cycle to execute. Sits between rename and execute. Generalises the fixed 16-entry, 3-operand, 2-broadcast issue stage to arbitrary depth, operand count and broadcast count. Adds oldest-first selection, an occupancy count, and a hold-on-stall output register.

## Interface
- DEPTH, 16, number of entries (power of two, ≥2)
- PAYLOAD_W, 138, opaque control payload width carried unchanged to execute
- NUM_SRC, 3, source operands per entry
- NUM_BCAST, 2, result broadcast channels (exe, mem, …)
- TAG_W, 6, physical-register tag width; tag 0 is the hardwired zero register
- DATA_W, 32, operand width
- AGE_W, 8, instruction sequence number width (wrapping)

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- FLUSH  in  1  synchronous squash of all entries
- enq_valid  in  1  rename presents an instruction
- enq_ready  out  1  a free entry exists (count < DEPTH)
- enq_payload  in  PAYLOAD_W  control payload
- enq_age  in  AGE_W  sequence number
- enq_serial  in  1  entry may issue only when it is the ROB head (hi/lo ops)
- enq_tag  in  NUM_SRC*TAG_W  source tags, slot k at [k*TAG_W +: TAG_W]
- enq_src_rdy  in  NUM_SRC  source value already valid
- enq_src_val  in  NUM_SRC*DATA_W  source values (immediate when tag 0)
- bcast_valid  in  NUM_BCAST  broadcast strobes
- bcast_tag  in  NUM_BCAST*TAG_W  broadcast tags
- bcast_val  in  NUM_BCAST*DATA_W  broadcast values
- head_age  in  AGE_W  sequence number at ROB head
- deq_ready  in  1  execute can accept (low = stall)
- deq_valid  out  1  output register holds an issued instruction
- deq_payload  out  PAYLOAD_W  issued payload
- deq_src_val  out  NUM_SRC*DATA_W  issued operands
- deq_age  out  AGE_W  issued sequence number
- count  out  $clog2(DEPTH)+1  valid entries

## Operation
- Per entry: valid, payload, age, serial, and per source tag, rdy, val.
- Enqueue (enq_valid & enq_ready & !FLUSH): write lowest-index invalid entry. Source k is rdy if enq_src_rdy[k], or tag==0, or a same-cycle broadcast matches the tag. A broadcast match also captures the value.
- Wakeup: for each valid entry and each not-ready source with tag≠0, a match on any valid broadcast channel sets rdy and captures val. Multiple matching channels: lowest channel index wins.
- Eligible = valid & all rdy & (!serial | age==head_age).
- Select: see Configuration. Executed only when deq_ready.
- Issue: the selected entry's fields load into deq_* and deq_valid←1. The entry's valid clears at the same edge. If deq_ready and nothing is eligible, deq_valid←0. If !deq_ready, deq_* and deq_valid hold and no entry issues.
- Age compare: a older than b iff MSB of (a−b) mod 2^AGE_W is 1.
- count = number of valid entries. It updates at the edge by +enq −issue; simultaneous enq and issue leaves it unchanged.

## Timing
- Reset (async, RESET low): all valid=0, deq_valid=0, deq_payload=0, deq_src_val=0, deq_age=0, count=0, enq_ready=1.
- Enqueue to earliest issue: entry enqueued at edge N is selectable at edge N+1, so deq_valid rises after N+1.
- Broadcast at edge N wakes the entry; it can issue at N+1. A broadcast does not make an entry eligible at the same edge.
- enq_ready is combinational from count only. A full queue with an issue in the same cycle still reports enq_ready=0.
- FLUSH at edge N: all entries invalid, deq_valid←0, count←0. Enqueue and issue in that cycle are dropped. FLUSH overrides deq_ready.
- head_age, bcast_* and deq_ready are sampled only at the posedge.

## Configuration
- AGE_SELECT_EN defined: select the oldest eligible entry by wrapped age compare; ties are impossible.
- AGE_SELECT_EN undefined: select the lowest-index eligible entry (priority encoder). Behaviour is otherwise identical.

## Test plan
- Reset then enqueue age 5, all tags 0, vals {1,2,3} → deq_valid=1 two edges later, deq_src_val={1,2,3}, deq_age=5, count returns 0.
- Enqueue tag 0x12 not ready; bcast ch1 tag 0x12 val 0xDEAD two cycles later → issues one edge after the broadcast with operand 0xDEAD. A broadcast in the enqueue cycle is also captured.
- Fill DEPTH entries with unready sources → enq_ready=0, count=DEPTH, further enq_valid ignored. One wakeup and issue → count=DEPTH−1, enq_ready=1.
- With AGE_SELECT_EN: ready entries ages 250, 3 (wrapped), 10 at indices 2,0,1 → issue order 250, 3, 10. Without the macro: order 3, 10, 250.
- Serial entry age 7, head_age=6 → not issued. head_age=7 → issues next edge.
- deq_ready=0 for 3 cycles with deq_valid=1 → outputs stable, count unchanged. FLUSH mid-stall → deq_valid=0, count=0 next edge.
